wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2.sv | 241 ++++++++++++++++++++++++
 tb/tb_wb_arb2.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// wb_arb2 -- two-master, one-slave Wishbone arbiter.
//
// Purpose:
//   Grants the shared slave to one of two Wishbone masters. A grant is held
//   for the whole of the master's cycle (bursts and multiple strobes
//   included). The bus returns to IDLE for one cycle between grants. Ties
//   are broken round-robin, and m0 wins the first tie after reset.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   When defined, a stall counter watches the granted strobe. After
//   TIMEOUT_CYCLES stalled cycles the arbiter moves to TOERR. It then drives
//   a one-cycle err to the granted master and pulses o_timeout. It keeps the
//   slave idle until that master drops cyc. When the macro is undefined there
//   is no counter and no TOERR state, and o_timeout is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  stalled strobe cycles before a timeout (1..255)
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   m{0,1}_wb_cyc/stb/we           master request controls
//   m{0,1}_wb_adr[23:0]            master address
//   m{0,1}_wb_o_dat[15:0]          master write data
//   m{0,1}_wb_sel[1:0]             master byte select
//   m{0,1}_wb_4_burst/8_burst      master burst hints
//   m{0,1}_wb_i_dat[15:0]          read data to master (always slave data)
//   m{0,1}_wb_ack/err              responses, routed to the granted master only
//   s_wb_*                         slave-side request outputs / response inputs
//   o_grant[1:0]                   one-hot grant (bit0 = m0), 2'b00 otherwise
//   o_timeout                      one-cycle pulse when a timeout error issues
module wb_arb2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        m0_wb_cyc,
    input  logic        m0_wb_stb,
    input  logic        m0_wb_we,
    input  logic [23:0] m0_wb_adr,
    input  logic [15:0] m0_wb_o_dat,
    input  logic [1:0]  m0_wb_sel,
    input  logic        m0_wb_4_burst,
    input  logic        m0_wb_8_burst,
    output logic [15:0] m0_wb_i_dat,
    output logic        m0_wb_ack,
    output logic        m0_wb_err,

    input  logic        m1_wb_cyc,
    input  logic        m1_wb_stb,
    input  logic        m1_wb_we,
    input  logic [23:0] m1_wb_adr,
    input  logic [15:0] m1_wb_o_dat,
    input  logic [1:0]  m1_wb_sel,
    input  logic        m1_wb_4_burst,
    input  logic        m1_wb_8_burst,
    output logic [15:0] m1_wb_i_dat,
    output logic        m1_wb_ack,
    output logic        m1_wb_err,

    output logic        s_wb_cyc,
    output logic        s_wb_stb,
    output logic        s_wb_we,
    output logic [23:0] s_wb_adr,
    output logic [15:0] s_wb_o_dat,
    output logic [1:0]  s_wb_sel,
    output logic        s_wb_4_burst,
    output logic        s_wb_8_burst,
    input  logic [15:0] s_wb_i_dat,
    input  logic        s_wb_ack,
    input  logic        s_wb_err,

    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    // Elaboration-time range check on the counter limit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_arb2: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
`ifdef WB_ARB_TIMEOUT_EN
        , TOERR
`endif
    } state_t;

    state_t state, state_nxt;
    logic   last_grant;      // 1 = m1 was granted most recently
    logic   last_grant_nxt;
    logic   sel0, sel1;

    assign sel0 = (state == GNT0);
    assign sel1 = (state == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_master;   // master that timed out (1 = m1)
    logic       to_pulse;    // high during the first TOERR cycle only
    logic       stall;
    logic       timeout_hit;

    assign stall = (sel0 || sel1) && s_wb_stb && !s_wb_ack && !s_wb_err;
    // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES,
    // so TOERR is entered on the same edge the count would reach the limit.
    assign timeout_hit = stall && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (m0_wb_cyc && m1_wb_cyc) begin
                    if (last_grant) begin
                        state_nxt      = GNT0;
                        last_grant_nxt = 1'b0;
                    end else begin
                        state_nxt      = GNT1;
                        last_grant_nxt = 1'b1;
                    end
                end else if (m0_wb_cyc) begin
                    state_nxt      = GNT0;
                    last_grant_nxt = 1'b0;
                end else if (m1_wb_cyc) begin
                    state_nxt      = GNT1;
                    last_grant_nxt = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_wb_cyc) begin
                    state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_nxt = TOERR;
`endif
                end
            end
            GNT1: begin
                if (!m1_wb_cyc) begin
                    state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_nxt = TOERR;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            TOERR: begin
                if (!(to_master ? m1_wb_cyc : m0_wb_cyc)) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            to_cnt    <= '0;
            to_master <= 1'b0;
            to_pulse  <= 1'b0;
        end else begin
            // The count clears on ack/err or on leaving the grant. It holds
            // while the strobe is low and nothing responds.
            if (!(sel0 || sel1) || state_nxt != state || s_wb_ack || s_wb_err) begin
                to_cnt <= '0;
            end else if (stall) begin
                to_cnt <= to_cnt + 8'd1;
            end
            to_pulse <= (state_nxt == TOERR) && (state != TOERR);
            if ((state_nxt == TOERR) && (state != TOERR)) begin
                to_master <= sel1;
            end
        end
    end
`endif

    // Slave-side request mux: zero unless a master holds the grant.
    always_comb begin
        s_wb_cyc     = 1'b0;
        s_wb_stb     = 1'b0;
        s_wb_we      = 1'b0;
        s_wb_adr     = '0;
        s_wb_o_dat   = '0;
        s_wb_sel     = '0;
        s_wb_4_burst = 1'b0;
        s_wb_8_burst = 1'b0;
        if (sel0) begin
            s_wb_cyc     = m0_wb_cyc;
            s_wb_stb     = m0_wb_stb;
            s_wb_we      = m0_wb_we;
            s_wb_adr     = m0_wb_adr;
            s_wb_o_dat   = m0_wb_o_dat;
            s_wb_sel     = m0_wb_sel;
            s_wb_4_burst = m0_wb_4_burst;
            s_wb_8_burst = m0_wb_8_burst;
        end else if (sel1) begin
            s_wb_cyc     = m1_wb_cyc;
            s_wb_stb     = m1_wb_stb;
            s_wb_we      = m1_wb_we;
            s_wb_adr     = m1_wb_adr;
            s_wb_o_dat   = m1_wb_o_dat;
            s_wb_sel     = m1_wb_sel;
            s_wb_4_burst = m1_wb_4_burst;
            s_wb_8_burst = m1_wb_8_burst;
        end
    end

    assign m0_wb_i_dat = s_wb_i_dat;
    assign m1_wb_i_dat = s_wb_i_dat;
    assign m0_wb_ack   = sel0 && s_wb_ack;
    assign m1_wb_ack   = sel1 && s_wb_ack;
    assign o_grant     = {sel1, sel0};

`ifdef WB_ARB_TIMEOUT_EN
    assign m0_wb_err = (sel0 && s_wb_err) || (to_pulse && !to_master);
    assign m1_wb_err = (sel1 && s_wb_err) || (to_pulse && to_master);
    assign o_timeout = to_pulse;
`else
    assign m0_wb_err = sel0 && s_wb_err;
    assign m1_wb_err = sel1 && s_wb_err;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2 -- self-checking bench for wb_arb2.
// Runs a directed sequence with literal expectations, then randomized
// traffic. Every cycle a behavioural ownership model is checked on the
// falling edge. The model tracks who owns the bus, the round-robin memory
// and, when WB_ARB_TIMEOUT_EN is defined, the stall count.
module tb_wb_arb2;

    localparam int TO = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic        mc_cyc[2], mc_stb[2], mc_we[2], mc_b4[2], mc_b8[2];
    logic [23:0] mc_adr[2];
    logic [15:0] mc_dat[2];
    logic [1:0]  mc_sel[2];
    logic [15:0] mi_dat[2];
    logic        m_ack[2], m_err[2];
    logic        s_wb_cyc, s_wb_stb, s_wb_we, s_wb_4_burst, s_wb_8_burst;
    logic [23:0] s_wb_adr;
    logic [15:0] s_wb_o_dat;
    logic [1:0]  s_wb_sel;
    logic [15:0] s_wb_i_dat;
    logic        s_wb_ack, s_wb_err;
    logic [1:0]  o_grant;
    logic        o_timeout;

    wb_arb2 #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .m0_wb_cyc(mc_cyc[0]), .m0_wb_stb(mc_stb[0]), .m0_wb_we(mc_we[0]),
        .m0_wb_adr(mc_adr[0]), .m0_wb_o_dat(mc_dat[0]), .m0_wb_sel(mc_sel[0]),
        .m0_wb_4_burst(mc_b4[0]), .m0_wb_8_burst(mc_b8[0]),
        .m0_wb_i_dat(mi_dat[0]), .m0_wb_ack(m_ack[0]), .m0_wb_err(m_err[0]),
        .m1_wb_cyc(mc_cyc[1]), .m1_wb_stb(mc_stb[1]), .m1_wb_we(mc_we[1]),
        .m1_wb_adr(mc_adr[1]), .m1_wb_o_dat(mc_dat[1]), .m1_wb_sel(mc_sel[1]),
        .m1_wb_4_burst(mc_b4[1]), .m1_wb_8_burst(mc_b8[1]),
        .m1_wb_i_dat(mi_dat[1]), .m1_wb_ack(m_ack[1]), .m1_wb_err(m_err[1]),
        .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
        .s_wb_adr(s_wb_adr), .s_wb_o_dat(s_wb_o_dat), .s_wb_sel(s_wb_sel),
        .s_wb_4_burst(s_wb_4_burst), .s_wb_8_burst(s_wb_8_burst),
        .s_wb_i_dat(s_wb_i_dat), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
        #1;
    endtask

    // Behavioural model: owner -1 = nobody, 0/1 = master index.
    int mo_owner = -1;
    int mo_last  = 1;
    int mo_cnt   = 0;
    bit mo_toerr = 1'b0;
    bit mo_pulse = 1'b0;
    int mo_pm    = 0;

    always @(posedge i_clk) begin : model
        bit np;
        int n;
        np = 1'b0;
        if (!i_rst_n) begin
            mo_owner = -1;
            mo_last  = 1;
            mo_cnt   = 0;
            mo_toerr = 1'b0;
        end else if (mo_toerr) begin
            if (!mc_cyc[mo_pm]) mo_toerr = 1'b0;
        end else if (mo_owner < 0) begin
            if (mc_cyc[0] && mc_cyc[1]) mo_owner = 1 - mo_last;
            else if (mc_cyc[0])         mo_owner = 0;
            else if (mc_cyc[1])         mo_owner = 1;
            if (mo_owner >= 0) mo_last = mo_owner;
            mo_cnt = 0;
        end else begin
            n = mo_owner;
            if (!mc_cyc[n]) begin
                mo_owner = -1;
                mo_cnt   = 0;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (s_wb_ack || s_wb_err) begin
                mo_cnt = 0;
            end else if (mc_stb[n]) begin
                if (mo_cnt + 1 == TO) begin
                    mo_owner = -1;
                    mo_toerr = 1'b1;
                    mo_pm    = n;
                    mo_cnt   = 0;
                    np       = 1'b1;
                end else begin
                    mo_cnt++;
                end
            end
`endif
        end
        mo_pulse = np;
    end

    always @(negedge i_clk) begin : compare
        logic [46:0] exp_req;
        logic [1:0]  exp_gnt;
        if (chk_en) begin
            exp_req = '0;
            exp_gnt = 2'b00;
            if (mo_owner >= 0) begin
                exp_req = {mc_cyc[mo_owner], mc_stb[mo_owner], mc_we[mo_owner],
                           mc_adr[mo_owner], mc_dat[mo_owner], mc_sel[mo_owner],
                           mc_b4[mo_owner], mc_b8[mo_owner]};
                exp_gnt = (mo_owner == 0) ? 2'b01 : 2'b10;
            end
            chk("grant", 64'(o_grant), 64'(exp_gnt));
            chk("s_req", 64'({s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_o_dat,
                              s_wb_sel, s_wb_4_burst, s_wb_8_burst}), 64'(exp_req));
            chk("timeout", 64'(o_timeout), 64'(mo_pulse));
            for (int n = 0; n < 2; n++) begin
                chk("m_ack", 64'(m_ack[n]), 64'((mo_owner == n) && s_wb_ack));
                chk("m_err", 64'(m_err[n]),
                    64'(((mo_owner == n) && s_wb_err) || (mo_pulse && mo_pm == n)));
                chk("m_i_dat", 64'(mi_dat[n]), 64'(s_wb_i_dat));
            end
        end
    end

    initial begin
        i_rst_n    = 1'b0;
        s_wb_i_dat = 16'h0000;
        s_wb_ack   = 1'b0;
        s_wb_err   = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mc_cyc[m] = 1'b0; mc_stb[m] = 1'b0; mc_we[m] = 1'b0;
            mc_adr[m] = '0;   mc_dat[m] = '0;   mc_sel[m] = '0;
            mc_b4[m]  = 1'b0; mc_b8[m]  = 1'b0;
        end
        step();
        step();
        chk_en = 1'b1;
        at_neg();
        chk("rst_grant", 64'(o_grant), 64'(2'b00));
        chk("rst_scyc", 64'(s_wb_cyc), 64'(1'b0));
        chk("rst_timeout", 64'(o_timeout), 64'(1'b0));
        step();
        i_rst_n = 1'b1;

        // m0 alone writes 0x0005 to 0x001001
        mc_cyc[0] = 1'b1; mc_stb[0] = 1'b1; mc_we[0] = 1'b1;
        mc_adr[0] = 24'h001001; mc_dat[0] = 16'h0005; mc_sel[0] = 2'b11;
        step();
        at_neg();
        chk("single_grant", 64'(o_grant), 64'(2'b01));
        chk("single_adr", 64'(s_wb_adr), 64'(24'h001001));
        chk("single_dat", 64'(s_wb_o_dat), 64'(16'h0005));
        s_wb_ack = 1'b1;
        #1;
        chk("single_ack0", 64'(m_ack[0]), 64'(1'b1));
        chk("single_ack1", 64'(m_ack[1]), 64'(1'b0));
        step();
        mc_cyc[0] = 1'b0; mc_stb[0] = 1'b0; s_wb_ack = 1'b0;
        step();
        step();

        // Tie: m0 first, one idle cycle, then m1, next tie back to m0
        mc_cyc[0] = 1'b1; mc_cyc[1] = 1'b1;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        step();
        at_neg();
        chk("tie1_grant", 64'(o_grant), 64'(2'b01));
        mc_cyc[0] = 1'b0;
        step();
        at_neg();
        chk("tie_gap", 64'(o_grant), 64'(2'b00));
        step();
        at_neg();
        chk("tie2_grant", 64'(o_grant), 64'(2'b10));
        mc_cyc[1] = 1'b0;
        step();
        at_neg();
        chk("tie_gap2", 64'(o_grant), 64'(2'b00));
        mc_cyc[0] = 1'b1; mc_cyc[1] = 1'b1;
        step();
        at_neg();
        chk("tie3_grant", 64'(o_grant), 64'(2'b01));
        mc_cyc[0] = 1'b0; mc_cyc[1] = 1'b0;
        step();
        step();

        // m1 8-beat burst while m0 waits
        mc_cyc[1] = 1'b1; mc_stb[1] = 1'b1; mc_b8[1] = 1'b1; mc_we[1] = 1'b0;
        step();
        mc_cyc[0] = 1'b1;
        s_wb_ack  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk("burst_grant", 64'(o_grant), 64'(2'b10));
            chk("burst_ack1", 64'(m_ack[1]), 64'(1'b1));
            step();
        end
        mc_cyc[1] = 1'b0; mc_stb[1] = 1'b0; mc_b8[1] = 1'b0; s_wb_ack = 1'b0;
        at_neg();
        chk("burst_release", 64'(o_grant), 64'(2'b10));
        step();
        at_neg();
        chk("burst_gap", 64'(o_grant), 64'(2'b00));
        step();
        at_neg();
        chk("burst_next", 64'(o_grant), 64'(2'b01));

        // Reset during a granted read with stb high
        mc_stb[0] = 1'b1; mc_we[0] = 1'b0; s_wb_ack = 1'b1; i_rst_n = 1'b0;
        step();
        at_neg();
        chk("rstx_grant", 64'(o_grant), 64'(2'b00));
        chk("rstx_scyc", 64'(s_wb_cyc), 64'(1'b0));
        chk("rstx_ack0", 64'(m_ack[0]), 64'(1'b0));
        chk("rstx_ack1", 64'(m_ack[1]), 64'(1'b0));
        step();
        i_rst_n = 1'b1; mc_cyc[0] = 1'b0; mc_stb[0] = 1'b0; s_wb_ack = 1'b0;
        step();
        step();

        // Stalled slave: timeout if enabled, indefinite hold otherwise
        mc_cyc[0] = 1'b1; mc_stb[0] = 1'b1;
        step();
        at_neg();
        chk("stall_grant", 64'(o_grant), 64'(2'b01));
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            at_neg();
            chk("stall_hold", 64'(o_grant), 64'(2'b01));
            chk("stall_noto", 64'(o_timeout), 64'(1'b0));
        end
        step();
        at_neg();
        chk("to_pulse", 64'(o_timeout), 64'(1'b1));
        chk("to_err0", 64'(m_err[0]), 64'(1'b1));
        chk("to_err1", 64'(m_err[1]), 64'(1'b0));
        chk("to_scyc", 64'(s_wb_cyc), 64'(1'b0));
        chk("to_grant", 64'(o_grant), 64'(2'b00));
        step();
        at_neg();
        chk("to_pulse_end", 64'(o_timeout), 64'(1'b0));
        chk("to_err_end", 64'(m_err[0]), 64'(1'b0));
        chk("to_hold_scyc", 64'(s_wb_cyc), 64'(1'b0));
`else
        for (int i = 0; i < 12; i++) begin
            step();
            at_neg();
            chk("stall_hold", 64'(o_grant), 64'(2'b01));
            chk("stall_noto", 64'(o_timeout), 64'(1'b0));
        end
`endif
        mc_cyc[0] = 1'b0; mc_stb[0] = 1'b0;
        step();
        step();
        at_neg();
        chk("stall_idle", 64'(o_grant), 64'(2'b00));

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(7) == 0) mc_cyc[m] = ~mc_cyc[m];
                mc_stb[m] = 1'($urandom_range(1));
                mc_we[m]  = 1'($urandom_range(1));
                mc_adr[m] = 24'($urandom);
                mc_dat[m] = 16'($urandom);
                mc_sel[m] = 2'($urandom);
                mc_b4[m]  = 1'($urandom_range(1));
                mc_b8[m]  = 1'($urandom_range(1));
            end
            s_wb_ack   = ($urandom_range(3) == 0);
            s_wb_err   = ($urandom_range(15) == 0);
            s_wb_i_dat = 16'($urandom);
            i_rst_n    = ($urandom_range(249) != 0);
        end
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
